wb_regfile: RTL

- Write-back-stage register file for the single-issue RV32I core. It sits directly downstream of the write-back data mux and consumes its 32-bit BusW result.
- Holds a one-entry write staging register, the 32x32 architectural register array, two combinational read ports with bypass, and a pending-write scoreboard.
- The scoreboard raises read hazards for decode/issue while a destination register is still in flight.

---
 rtl/core_pkg.sv | 16 +
 rtl/wb_scoreboard.sv | 92 +++++++++
 rtl/wb_regfile.sv | 110 +++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core types and constants for the write-back stage and its register file.
package core_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on write-back, wiped by flush.
// WB_REGFILE_BYPASS_EN selects whether a write-back in flight still counts as a hazard.
module wb_scoreboard
  import core_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_valid,
  input  logic                 wb_we,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 iss_valid,
  input  logic                 iss_we,
  input  logic [REG_IDX_W-1:0] iss_rd,
  input  logic                 flush,
`ifndef WB_REGFILE_BYPASS_EN
  input  logic                 stg_valid,
  input  logic [REG_IDX_W-1:0] stg_rd,
`endif
  input  logic [REG_IDX_W-1:0] ra1,
  input  logic [REG_IDX_W-1:0] ra2,
  output logic                 haz1,
  output logic                 haz2,
  output logic                 sb_busy
);

  localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

  logic [NREG-1:0] pend_r;
  logic [NREG-1:0] pend_nxt_s;
  logic [NREG-1:0] set_s;
  logic [NREG-1:0] clr_s;
  logic            sb_busy_r;
  logic            wb_acc_s;
  logic            iss_acc_s;

  assign wb_acc_s  = wb_valid && wb_we && (wb_rd != ZERO_REG);
  assign iss_acc_s = iss_valid && iss_we && (iss_rd != ZERO_REG);

  // Next pending set: flush beats everything, and a same-cycle issue beats the clear.
  always_comb begin
    set_s      = '0;
    clr_s      = '0;
    pend_nxt_s = pend_r;
    if (wb_acc_s) begin
      clr_s = ONE_HOT0 << wb_rd;
    end else begin
      clr_s = '0;
    end
    if (iss_acc_s) begin
      set_s = ONE_HOT0 << iss_rd;
    end else begin
      set_s = '0;
    end
    if (flush) begin
      pend_nxt_s = '0;
    end else begin
      pend_nxt_s = ((pend_r & ~clr_s) | set_s) & ~ONE_HOT0;
    end
  end

  // Pending bits and the registered busy flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_r    <= '0;
      sb_busy_r <= 1'b0;
    end else begin
      pend_r    <= pend_nxt_s;
      sb_busy_r <= |pend_nxt_s;
    end
  end

  // Per-port hazard compare.
  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
`ifdef WB_REGFILE_BYPASS_EN
    haz1 = pend_r[ra1] && (ra1 != ZERO_REG) && !(wb_valid && wb_we && (wb_rd == ra1));
    haz2 = pend_r[ra2] && (ra2 != ZERO_REG) && !(wb_valid && wb_we && (wb_rd == ra2));
`else
    // Without bypass the value is unreadable until it lands in the array.
    haz1 = (ra1 != ZERO_REG) && (pend_r[ra1] || (wb_valid && wb_we && (wb_rd == ra1))
                                 || (stg_valid && (stg_rd == ra1)));
    haz2 = (ra2 != ZERO_REG) && (pend_r[ra2] || (wb_valid && wb_we && (wb_rd == ra2))
                                 || (stg_valid && (stg_rd == ra2)));
`endif
  end

  assign sb_busy = sb_busy_r;

endmodule

// File: rtl/wb_regfile.sv
// Write-back register file: staging register, reset 32x32 array, bypassed read ports, scoreboard.
// Define WB_REGFILE_BYPASS_EN to forward in-flight write-back/staging data to the read ports.
module wb_regfile
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_valid,
  input  logic                 wb_we,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      busw,
  input  logic                 iss_valid,
  input  logic                 iss_we,
  input  logic [REG_IDX_W-1:0] iss_rd,
  input  logic                 flush,
  input  logic [REG_IDX_W-1:0] ra1,
  input  logic [REG_IDX_W-1:0] ra2,
  output logic [XLEN-1:0]      rd1,
  output logic [XLEN-1:0]      rd2,
  output logic                 haz1,
  output logic                 haz2,
  output logic                 sb_busy
);

  logic [XLEN-1:0] regs_r [NREG];
  wb_req_t         stg_r;
  logic            wb_acc_s;

  assign wb_acc_s = wb_valid && wb_we && (wb_rd != ZERO_REG);

  // Pick a read value: x0 is constant zero, then incoming wb, staging, array.
  function automatic logic [XLEN-1:0] read_port(
    input logic [REG_IDX_W-1:0] ra,
    input logic                 wb_hit,
    input logic [XLEN-1:0]      wb_data,
    input logic                 stg_hit,
    input logic [XLEN-1:0]      stg_data,
    input logic [XLEN-1:0]      arr_data
  );
    logic [XLEN-1:0] val;
    if (ra == ZERO_REG) begin
      val = '0;
    end else if (wb_hit) begin
      val = wb_data;
    end else if (stg_hit) begin
      val = stg_data;
    end else begin
      val = arr_data;
    end
    return val;
  endfunction

  // Array commit from staging, and staging load from write-back; reset drops any staged write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
      stg_r <= '0;
    end else begin
      if (stg_r.valid && stg_r.we) begin
        regs_r[stg_r.rd] <= stg_r.data;
      end
      stg_r.valid <= wb_acc_s;
      stg_r.we    <= wb_acc_s;
      stg_r.rd    <= wb_rd;
      stg_r.data  <= busw;
    end
  end

  // Read ports.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
`ifdef WB_REGFILE_BYPASS_EN
    rd1 = read_port(ra1, wb_valid && wb_we && (wb_rd == ra1), busw,
                    stg_r.valid && (stg_r.rd == ra1), stg_r.data, regs_r[ra1]);
    rd2 = read_port(ra2, wb_valid && wb_we && (wb_rd == ra2), busw,
                    stg_r.valid && (stg_r.rd == ra2), stg_r.data, regs_r[ra2]);
`else
    rd1 = read_port(ra1, 1'b0, busw, 1'b0, stg_r.data, regs_r[ra1]);
    rd2 = read_port(ra2, 1'b0, busw, 1'b0, stg_r.data, regs_r[ra2]);
`endif
  end

  wb_scoreboard #(.NREG(NREG)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .iss_valid (iss_valid),
    .iss_we    (iss_we),
    .iss_rd    (iss_rd),
    .flush     (flush),
`ifndef WB_REGFILE_BYPASS_EN
    .stg_valid (stg_r.valid),
    .stg_rd    (stg_r.rd),
`endif
    .ra1       (ra1),
    .ra2       (ra2),
    .haz1      (haz1),
    .haz2      (haz2),
    .sb_busy   (sb_busy)
  );

endmodule
